// File: rtl/ship_status_tracker.sv
// ship_status_tracker: ship health, score and invulnerability datapath for the game FSM.
// Applies events once per update window, blinks the game-over LEDs.
module ship_status_tracker #(
    parameter logic [3:0]  START_HEALTH = 4'd7,
    parameter logic [3:0]  INVULN_TICKS = 4'd8,
    parameter logic [27:0] BLINK_DIV    = 28'd25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startGameEn,
    input  logic        shipUpdateEn,
    input  logic        gameOverEn,
    input  logic        hit_event,
    input  logic        kill_event,
    output logic [3:0]  ship_health,
    output logic [7:0]  current_highscore,
    output logic        invuln,
    output logic        update_done,
    output logic [17:0] ledr,
    output logic [7:0]  ledg
);
    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_ACK, S_FROZEN} state_t;
    state_t state, state_nx;
    logic shipUpdateEn_d, pending_hit, blink_phase, apply, blink_wrap;
    logic [2:0] pending_kills, kills_base;
    logic [3:0] invuln_cnt;
    logic [27:0] blink_cnt;
    logic [8:0] score_sum;

    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : state_nx;
        shipUpdateEn_d <= reset ? 1'b0 : shipUpdateEn;
    end

    always_comb begin
        state_nx = startGameEn ? S_IDLE :
                   (gameOverEn || state == S_FROZEN) ? S_FROZEN :
                   state == S_APPLY ? S_ACK :
                   (state == S_IDLE && shipUpdateEn && !shipUpdateEn_d) ? S_APPLY : S_IDLE;
        apply = state == S_APPLY && !startGameEn && !gameOverEn;
        // an event arriving in the apply cycle merges with the clear and survives
        kills_base = apply ? 3'd0 : pending_kills;
        score_sum = {1'b0, current_highscore} + {6'd0, pending_kills};
        blink_wrap = blink_cnt == BLINK_DIV - 28'd1;
    end

    assign invuln = invuln_cnt != 4'd0;
    assign update_done = state == S_ACK;
    assign ledr = {18{state == S_FROZEN && blink_phase && ship_health == 4'd0}};
    assign ledg = {8{state == S_FROZEN && blink_phase && current_highscore == 8'hFF}};

    always_ff @(posedge clk) begin
        if (reset || startGameEn) begin
            ship_health <= START_HEALTH;
            current_highscore <= 8'd0;
            invuln_cnt <= 4'd0;
            pending_hit <= 1'b0;
            pending_kills <= 3'd0;
            blink_cnt <= 28'd0;
            blink_phase <= 1'b0;
        end else if (state == S_FROZEN) begin
            blink_cnt <= blink_wrap ? 28'd0 : blink_cnt + 28'd1;
            blink_phase <= blink_phase ^ blink_wrap;
        end else begin
            if (apply) begin
                if (pending_hit && invuln_cnt == 4'd0 && ship_health != 4'd0) begin
                    ship_health <= ship_health - 4'd1;
                    invuln_cnt <= INVULN_TICKS;
                end else if (invuln_cnt != 4'd0) begin
                    invuln_cnt <= invuln_cnt - 4'd1;
                end
                current_highscore <= score_sum[8] ? 8'hFF : score_sum[7:0];
            end
            pending_hit <= (pending_hit && !apply) || hit_event;
            pending_kills <= (kill_event && kills_base != 3'd7) ? kills_base + 3'd1 : kills_base;
        end
    end
endmodule

// File: doc/ship_status_tracker.md
Name: ship_status_tracker

Overview:
- Datapath responder to the game control FSM. It consumes the FSM's startGameEn, shipUpdateEn and gameOverEn enables, and collision pulses from the grid logic.
- It produces ship_health and current_highscore, which the FSM uses to decide game over. It also produces the invulnerability flag and the game-over LED blink patterns.
- Events are accumulated between update windows and applied exactly once per window.

Parameters:
- START_HEALTH, 4'd7, health loaded on reset and at game start.
- INVULN_TICKS, 4'd8, number of update windows the ship ignores hits after taking one.
- BLINK_DIV, 28'd25_000_000, clk cycles per LED blink phase (0.5 s at 50 MHz).

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- startGameEn  in  1  level from the FSM; reinitialise game variables while high.
- shipUpdateEn  in  1  level from the FSM; high for the whole update window.
- gameOverEn  in  1  level from the FSM; game over, freeze and blink.
- hit_event  in  1  1-cycle pulse: ship collided with an enemy or projectile.
- kill_event  in  1  1-cycle pulse: an enemy was destroyed by the ship.
- ship_health  out  4  current health, to the FSM.
- current_highscore  out  8  current score, to the FSM; saturates at 8'hFF.
- invuln  out  1  high while the invulnerability counter is non-zero.
- update_done  out  1  1-cycle pulse after an update has been applied.
- ledr  out  18  loss blink pattern.
- ledg  out  8  win blink pattern.

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high; clock is clk.
  - Reset values: ship_health=START_HEALTH, current_highscore=0, invuln=0, update_done=0, ledr=0, ledg=0.
  - Internal reset values: pending_hit=0, pending_kills=0, invuln_cnt=0, blink_cnt=0, blink_phase=0, shipUpdateEn_d=0. FSM goes to S_IDLE.
- Priority: reset > startGameEn > gameOverEn > update/event logic.
- FSM states: S_IDLE, S_APPLY, S_ACK, S_FROZEN.
- S_IDLE:
  - Accumulate events.
  - A rising edge of shipUpdateEn (shipUpdateEn=1 and shipUpdateEn_d=0) moves to S_APPLY.
  - gameOverEn=1 moves to S_FROZEN.
- S_APPLY (one cycle), performed on the transition out of this state:
  - If pending_hit=1, invuln_cnt=0 and ship_health>0: ship_health decrements by 1 and invuln_cnt loads INVULN_TICKS.
  - Otherwise, if invuln_cnt>0, invuln_cnt decrements by 1. A hit while invulnerable is discarded.
  - current_highscore becomes min(current_highscore + pending_kills, 8'hFF). Compute in 9 bits, then clamp.
  - pending_hit and pending_kills clear. Next state is S_ACK.
- S_ACK (one cycle): update_done=1, then S_IDLE.
  - A shipUpdateEn level held for the rest of the window causes no further applies.
  - Update latency: the new ship_health and current_highscore are visible 2 cycles after the shipUpdateEn rising edge. update_done pulses in that same cycle.
- Event accumulation (in every non-frozen state):
  - hit_event sets pending_hit (sticky).
  - kill_event increments pending_kills (3 bits, saturating at 7).
  - An event in the same cycle as the S_APPLY clear is retained for the next window, not lost: the clear and the set merge, so pending=event.
  - hit_event and kill_event in the same cycle are both recorded.
- startGameEn=1, in any state:
  - ship_health=START_HEALTH, current_highscore=0, invuln_cnt=0, pending cleared, blink cleared, ledr=ledg=0.
  - FSM goes to S_IDLE. Events are ignored while it is high.
- S_FROZEN, entered when gameOverEn=1:
  - ship_health and current_highscore hold. Events are ignored. update_done=0.
  - blink_cnt counts 0..BLINK_DIV-1 and wraps; blink_phase toggles on each wrap.
  - ledr = {18{blink_phase}} if ship_health==0, else 0.
  - ledg = {8{blink_phase}} if current_highscore==8'hFF, else 0.
  - Only reset or startGameEn leaves S_FROZEN.
- Invariants:
  - ship_health never underflows below 0.
  - invuln == (invuln_cnt != 0).
  - current_highscore never wraps past 8'hFF.

Test Plan:
- Reset, then startGameEn for 3 cycles -> ship_health=7, score=0, invuln=0, ledr=ledg=0.
- 3 kill_event pulses plus 1 hit_event, then shipUpdateEn high for 100 cycles -> exactly one apply; 2 cycles after the edge, health=6, score=3, invuln=1, a single update_done pulse.
- hit_event during each of the next 8 update windows -> health stays 6; invuln falls after the 8th window; a hit in the 9th window -> health=5.
- Score preloaded to 8'hFD, then 7 kills and an update -> score=8'hFF with no wrap. kill_event in the S_APPLY cycle -> pending_kills=1 for the next window.
- Health driven to 0, then gameOverEn -> ledr toggles all-ones/zero every 25_000_000 cycles (shorten BLINK_DIV=4 in the bench), ledg=0, and events are ignored.
- In S_FROZEN, assert startGameEn -> health=7, score=0, LEDs=0, state S_IDLE. Assert reset in S_APPLY -> all reset values, no update_done pulse.
